// File: rtl/cc_datadelay_seq_pkg.sv
// Shared types and defaults for the data-delay sequencer: FSM encoding,
// default widths and the packed-bus slice helper.
package cc_datadelay_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } seq_state_t;

  localparam int DEF_NREQ          = 4;
  localparam int DEF_DATAWIDTH_BUS = 8;
  localparam int DEF_CNTW          = 8;
  localparam int DEF_IDW           = 2;

  // LSB of requester idx inside the packed data bus.
  function automatic int data_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cc_datadelay_seq_if.sv
// Requester-side bus of the data-delay sequencer; the sequencer uses the
// slave modport, the producer/consumer side uses master.
interface cc_datadelay_seq_if
  import cc_datadelay_seq_pkg::*;
#(
  parameter int NREQ          = DEF_NREQ,
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int CNTW          = DEF_CNTW,
  parameter int IDW           = DEF_IDW
);

  logic                          CC_DATADELAY_SEQ_Tick_In;
  logic [NREQ-1:0]               CC_DATADELAY_SEQ_Req_InBus;
  logic [NREQ*DATAWIDTH_BUS-1:0] CC_DATADELAY_SEQ_Data_InBus;
  logic [CNTW-1:0]               CC_DATADELAY_SEQ_DelayTicks_InBus;
  logic [DATAWIDTH_BUS-1:0]      CC_DATADELAY_SEQ_DelayedData_OutBus;
  logic                          CC_DATADELAY_SEQ_Valid_Out;
  logic [NREQ-1:0]               CC_DATADELAY_SEQ_Ack_OutBus;
  logic [IDW-1:0]                CC_DATADELAY_SEQ_GrantId_OutBus;
  logic                          CC_DATADELAY_SEQ_Busy_Out;

  modport master (
    output CC_DATADELAY_SEQ_Tick_In,
    output CC_DATADELAY_SEQ_Req_InBus,
    output CC_DATADELAY_SEQ_Data_InBus,
    output CC_DATADELAY_SEQ_DelayTicks_InBus,
    input  CC_DATADELAY_SEQ_DelayedData_OutBus,
    input  CC_DATADELAY_SEQ_Valid_Out,
    input  CC_DATADELAY_SEQ_Ack_OutBus,
    input  CC_DATADELAY_SEQ_GrantId_OutBus,
    input  CC_DATADELAY_SEQ_Busy_Out
  );

  modport slave (
    input  CC_DATADELAY_SEQ_Tick_In,
    input  CC_DATADELAY_SEQ_Req_InBus,
    input  CC_DATADELAY_SEQ_Data_InBus,
    input  CC_DATADELAY_SEQ_DelayTicks_InBus,
    output CC_DATADELAY_SEQ_DelayedData_OutBus,
    output CC_DATADELAY_SEQ_Valid_Out,
    output CC_DATADELAY_SEQ_Ack_OutBus,
    output CC_DATADELAY_SEQ_GrantId_OutBus,
    output CC_DATADELAY_SEQ_Busy_Out
  );

endinterface

// File: rtl/cc_rr_arbiter.sv
// Round-robin priority encoder: first active request at or after ptr,
// scanning upward with wrap. Purely combinational.
module cc_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_req
);

  logic           found;
  logic [IDW-1:0] cand;

  // NREQ is a power of two, so the IDW-bit add wraps the scan for free.
  always_comb begin
    gnt_idx = ptr;
    any_req = |req;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + IDW'(i);
      if (!found && req[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_datadelay_sequencer.sv
// Shared data-delay stage: round-robin grant, capture, wait N time-base
// ticks, then one registered send with a one-hot ack to the winner.
//
// state   | meaning
// ST_IDLE | waiting for any request; grant + capture on the request edge
// ST_WAIT | counting ticks down to the terminal count of 1 -> 0
// ST_SEND | one cycle: Valid and Ack high, DelayedData already updated
module cc_datadelay_sequencer
  import cc_datadelay_seq_pkg::*;
#(
  parameter int NREQ          = DEF_NREQ,
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int CNTW          = DEF_CNTW,
  parameter int IDW           = DEF_IDW
) (
  input  logic               CC_DATADELAY_SEQ_CLOCK_50,
  input  logic               CC_DATADELAY_SEQ_RESET_InHigh,
  cc_datadelay_seq_if.slave  seq_bus
);

  seq_state_t               state_q, state_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [DATAWIDTH_BUS-1:0] hold_q, hold_d;
  logic [DATAWIDTH_BUS-1:0] dout_q, dout_d;
  logic [IDW-1:0]           gid_q, gid_d;
  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [IDW-1:0]           gnt_idx;
  logic                     any_req;
  logic [DATAWIDTH_BUS-1:0] sel_data;

  cc_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (seq_bus.CC_DATADELAY_SEQ_Req_InBus),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i))
        sel_data = seq_bus.CC_DATADELAY_SEQ_Data_InBus[data_lsb(i, DATAWIDTH_BUS) +: DATAWIDTH_BUS];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          hold_d = sel_data;
          cnt_d  = seq_bus.CC_DATADELAY_SEQ_DelayTicks_InBus;
          gid_d  = gnt_idx;
          // Zero delay skips the hold register so the send lands next cycle.
          if (seq_bus.CC_DATADELAY_SEQ_DelayTicks_InBus == '0) begin
            state_d = ST_SEND;
            dout_d  = sel_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (seq_bus.CC_DATADELAY_SEQ_Tick_In && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = ST_SEND;
            dout_d  = hold_q;
          end
        end
      end
      ST_SEND: begin
        state_d = ST_IDLE;
        ptr_d   = gid_q + IDW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CC_DATADELAY_SEQ_CLOCK_50) begin
    if (CC_DATADELAY_SEQ_RESET_InHigh) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign seq_bus.CC_DATADELAY_SEQ_DelayedData_OutBus = dout_q;
  assign seq_bus.CC_DATADELAY_SEQ_GrantId_OutBus     = gid_q;
  assign seq_bus.CC_DATADELAY_SEQ_Valid_Out          = (state_q == ST_SEND);
  assign seq_bus.CC_DATADELAY_SEQ_Ack_OutBus         = (state_q == ST_SEND) ? (NREQ'(1) << gid_q) : '0;
  assign seq_bus.CC_DATADELAY_SEQ_Busy_Out           = (state_q == ST_WAIT) || (state_q == ST_SEND);

endmodule

// File: doc/cc_datadelay_sequencer.md
Name: cc_datadelay_sequencer

Overview:
- Sequences the shared data-delay stage between up to NREQ requesters, e.g. the lane/sprite update sources in the game core.
- Arbitrates round-robin and captures the winner's bus into an internal hold register.
- Waits a programmable number of time-base ticks, then fires a single registered send that drives the delayed bus and acknowledges the winner.
- Sits between the game-logic producers and the display/collision consumers.

Parameters:
DATAWIDTH_BUS, 8, width of each requester data bus and of the delayed output.
NREQ, 4, number of requesters (power of 2, 2..8).
CNTW, 8, width of the delay-tick counter; maximum delay is 2^CNTW-1 ticks.
IDW, 2, grant-index width, equal to log2(NREQ).

Ports:
CC_DATADELAY_SEQ_CLOCK_50  in  1  system clock; all logic on its rising edge.
CC_DATADELAY_SEQ_RESET_InHigh  in  1  synchronous, active-high reset.
CC_DATADELAY_SEQ_Tick_In  in  1  one-cycle time-base enable.
CC_DATADELAY_SEQ_Req_InBus  in  NREQ  request per requester, level.
CC_DATADELAY_SEQ_Data_InBus  in  NREQ*DATAWIDTH_BUS  packed data; requester i occupies bits [i*DATAWIDTH_BUS +: DATAWIDTH_BUS].
CC_DATADELAY_SEQ_DelayTicks_InBus  in  CNTW  delay in ticks, sampled at grant.
CC_DATADELAY_SEQ_DelayedData_OutBus  out  DATAWIDTH_BUS  delayed data; holds the last sent value.
CC_DATADELAY_SEQ_Valid_Out  out  1  one-cycle pulse when DelayedData updates.
CC_DATADELAY_SEQ_Ack_OutBus  out  NREQ  one-hot, one-cycle acknowledge to the served requester.
CC_DATADELAY_SEQ_GrantId_OutBus  out  IDW  index of the current or last winner.
CC_DATADELAY_SEQ_Busy_Out  out  1  high in WAIT and SEND.

Behaviour:
- Reset (sync, mid-operation included):
  - state=IDLE, rr pointer=0.
  - Hold register, counter and every output = 0.
  - An in-flight transfer is dropped with no Ack.
- FSM states: IDLE=0, WAIT=1, SEND=2. Moore outputs are decoded from the registered state.
- IDLE:
  - If any Req is high, the winner is the first requester at or after the pointer, scanning upward with wrap.
  - On that edge: capture the winner's data into the hold register, load the counter with DelayTicks, set GrantId.
  - Next state: SEND if DelayTicks==0, else WAIT. No Req: stay in IDLE.
- WAIT:
  - Each cycle with Tick_In=1 decrements the counter; on the tick that takes the counter 1->0, go to SEND.
  - A Tick in the grant cycle (IDLE) is not counted.
  - DelayTicks and Data changes during WAIT are ignored.
  - Req deassertion during WAIT does not abort; the transfer completes and is acked.
- SEND, exactly one cycle:
  - Valid_Out=1; Ack_OutBus bit GrantId=1.
  - DelayedData_OutBus was loaded from the hold register on the edge entering SEND, so it is valid in the same cycle as Valid.
  - On exit: pointer=(GrantId+1) mod NREQ; next state IDLE.
- Latency:
  - DelayTicks=0: Req sampled at edge k gives Valid/Ack in cycle k+1. Earliest next grant is at edge k+2.
  - DelayTicks=N: Valid is in the cycle after the edge that samples the Nth counted tick.
- Requesters drop Req in the Ack cycle. A Req still high in IDLE after its Ack is treated as a new request, with lower priority because the pointer has moved.
- Outside SEND: Valid=0, Ack=0, DelayedData and GrantId hold.
- Busy_Out=1 in WAIT and SEND.
- The counter never underflows and no combinational paths run from inputs to outputs.

Decomposition:
- Package cc_datadelay_seq_pkg holds:
  - state encodings ST_IDLE, ST_WAIT, ST_SEND (2 bits);
  - default NREQ, DATAWIDTH_BUS, CNTW;
  - a helper function for the packed data slice.
- Sub-module cc_rr_arbiter (NREQ, IDW):
  - combinational pointer-rotated priority encoder;
  - outputs a grant index and any-request flag.
- The FSM, counter, hold register and output registers stay in the top.

Test Plan:
1. Reset held 3 cycles with Req=4'b1111 -> all outputs 0, Busy=0. After release, first grant is requester 0.
2. Req0 with data 0xA5, DelayTicks=3, Tick every 4th cycle -> Busy high until 3 ticks are counted. Then a single Valid cycle with DelayedData=0xA5, Ack=4'b0001, GrantId=0.
3. DelayTicks=0, Req1 with data 0x3C sampled at edge k -> Valid and Ack=4'b0010 in cycle k+1; DelayedData holds 0x3C afterwards.
4. All four Req held with data 0x10..0x13, DelayTicks=0, each requester re-raising Req 2 cycles after its Ack -> grant order 0,1,2,3,0. Each Ack lasts one cycle and never overlaps another.
5. Req2 granted with DelayTicks=5; DelayTicks changed to 9 and a Tick is applied in the grant cycle -> send follows exactly 5 ticks counted in WAIT.
6. Reset asserted mid-WAIT (2 of 5 ticks done) -> no Ack or Valid, outputs 0. A following Req3 alone is granted normally with GrantId=3.
